stream_delay_line: RTL and testbench

- Parametrised multichannel streaming delay line with a per-beat valid qualifier, fill tracking, synchronous flush and an output valid strobe.
- Successor to the fixed single-channel top-level delay/FIFO datapath.
- Each accepted beat shifts all channels one stage. Output is the sample accepted DEPTH beats earlier, flagged valid once the line is primed.
- Sits between a sample source and downstream per-sample processing.

---
 rtl/stream_delay_line.sv | 96 +++++++++
 tb/tb_stream_delay_line.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_delay_line.sv
// Multichannel streaming delay line: DEPTH-beat delay with fill tracking, flush and valid strobe.
// Optional per-lane running sum of the stored samples when STREAM_DELAY_SUM_EN is defined.
module stream_delay_line #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 2,
    parameter int CHANNELS = 1,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    input  logic [CHANNELS*WIDTH-1:0]     i_data,
    input  logic                          i_flush,
    output logic [CHANNELS*WIDTH-1:0]     o_data,
    output logic                          o_valid,
    output logic [CNT_W-1:0]              o_fill
`ifdef STREAM_DELAY_SUM_EN
    ,
    output logic [CHANNELS*(WIDTH+CNT_W)-1:0] o_sum
`endif
);

    localparam int               DW       = CHANNELS * WIDTH;
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);

    logic [DW-1:0]    r_stage [DEPTH];
    logic [DW-1:0]    r_data;
    logic             r_valid;
    logic [CNT_W-1:0] r_fill;
    logic             w_full;

    assign w_full  = (r_fill == FILL_MAX);
    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_fill  = r_fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_fill  <= '0;
        end else if (i_flush) begin
            // Flush wipes old contents; a coincident beat becomes the new beat 0.
            for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
            r_valid <= 1'b0;
            if (i_valid) begin
                r_stage[0] <= i_data;
                r_fill     <= CNT_W'(1);
            end else begin
                r_fill     <= '0;
            end
        end else if (i_valid) begin
            r_data     <= r_stage[DEPTH-1];
            r_valid    <= w_full;
            r_stage[0] <= i_data;
            for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
            if (!w_full) r_fill <= r_fill + 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

`ifdef STREAM_DELAY_SUM_EN
    localparam int SW = WIDTH + CNT_W;

    logic [CHANNELS*SW-1:0] r_sum;
    logic [CHANNELS*SW-1:0] w_sum_step;
    logic [CHANNELS*SW-1:0] w_sum_load;

    // Modular add/subtract is exact: the true sum is non-negative and fits in SW bits.
    always_comb begin
        w_sum_step = '0;
        w_sum_load = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_sum_step[c*SW +: SW] = r_sum[c*SW +: SW]
                                   + SW'(i_data[c*WIDTH +: WIDTH])
                                   - SW'(r_stage[DEPTH-1][c*WIDTH +: WIDTH]);
            w_sum_load[c*SW +: SW] = SW'(i_data[c*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (i_flush) begin
            r_sum <= i_valid ? w_sum_load : '0;
        end else if (i_valid) begin
            r_sum <= w_sum_step;
        end
    end

    assign o_sum = r_sum;
`endif

endmodule

// File: tb/tb_stream_delay_line.sv
// Directed self-checking bench for stream_delay_line: default, DEPTH=1 and 3-lane/DEPTH=4 instances.
module tb_stream_delay_line;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instance A: WIDTH=8, DEPTH=2, CHANNELS=1
    logic       rst_a = 1'b1, v_a = 1'b0, f_a = 1'b0;
    logic [7:0] d_a = '0, od_a;
    logic       ov_a;
    logic [1:0] of_a;
`ifdef STREAM_DELAY_SUM_EN
    logic [9:0] sum_a;
`endif

    stream_delay_line #(.WIDTH(8), .DEPTH(2), .CHANNELS(1)) u_dut_a (
        .clk(clk), .rst(rst_a), .i_valid(v_a), .i_data(d_a), .i_flush(f_a),
        .o_data(od_a), .o_valid(ov_a), .o_fill(of_a)
`ifdef STREAM_DELAY_SUM_EN
        , .o_sum(sum_a)
`endif
    );

    // Instance D1: DEPTH=1
    logic       rst_1 = 1'b1, v_1 = 1'b0, f_1 = 1'b0;
    logic [7:0] d_1 = '0, od_1;
    logic       ov_1;
    logic [0:0] of_1;
`ifdef STREAM_DELAY_SUM_EN
    logic [8:0] sum_1;
`endif

    stream_delay_line #(.WIDTH(8), .DEPTH(1), .CHANNELS(1)) u_dut_d1 (
        .clk(clk), .rst(rst_1), .i_valid(v_1), .i_data(d_1), .i_flush(f_1),
        .o_data(od_1), .o_valid(ov_1), .o_fill(of_1)
`ifdef STREAM_DELAY_SUM_EN
        , .o_sum(sum_1)
`endif
    );

    // Instance M: WIDTH=8, DEPTH=4, CHANNELS=3
    logic        rst_m = 1'b1, v_m = 1'b0, f_m = 1'b0;
    logic [23:0] d_m = '0, od_m;
    logic        ov_m;
    logic [2:0]  of_m;
`ifdef STREAM_DELAY_SUM_EN
    logic [32:0] sum_m;
`endif

    stream_delay_line #(.WIDTH(8), .DEPTH(4), .CHANNELS(3)) u_dut_m (
        .clk(clk), .rst(rst_m), .i_valid(v_m), .i_data(d_m), .i_flush(f_m),
        .o_data(od_m), .o_valid(ov_m), .o_fill(of_m)
`ifdef STREAM_DELAY_SUM_EN
        , .o_sum(sum_m)
`endif
    );

    task automatic beat_a(input logic [7:0] d, input logic [7:0] exp_d, input logic exp_v,
                          input logic [1:0] exp_f);
        v_a = 1'b1; f_a = 1'b0; d_a = d;
        step();
        check("a_data", 64'(od_a), 64'(exp_d));
        check("a_valid", 64'(ov_a), 64'(exp_v));
        check("a_fill", 64'(of_a), 64'(exp_f));
    endtask

    task automatic pulse_reset_a();
        v_a = 1'b0; f_a = 1'b0; rst_a = 1'b1;
        step();
        rst_a = 1'b0;
    endtask

    task automatic check_m_zero(input string tag);
        check({tag, "_data"}, 64'(od_m), 64'd0);
        check({tag, "_valid"}, 64'(ov_m), 64'd0);
        check({tag, "_fill"}, 64'(of_m), 64'd0);
`ifdef STREAM_DELAY_SUM_EN
        check({tag, "_sum"}, 64'(sum_m), 64'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        // Reset hold with live input
        v_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_a = 8'($urandom);
            step();
            check("rst_data", 64'(od_a), 64'd0);
            check("rst_valid", 64'(ov_a), 64'd0);
            check("rst_fill", 64'(of_a), 64'd0);
        end
        rst_a = 1'b0;

        // Basic delay, back-to-back beats
        for (int n = 0; n < 10; n++)
            beat_a(8'(n), (n >= 2) ? 8'(n - 2) : 8'd0, n >= 2, (n >= 1) ? 2'd2 : 2'd1);

        // Gapped input: idle cycles hold data/fill and never strobe valid
        pulse_reset_a();
        for (int n = 0; n < 10; n++) begin
            beat_a(8'(n), (n >= 2) ? 8'(n - 2) : 8'd0, n >= 2, (n >= 1) ? 2'd2 : 2'd1);
            v_a = 1'b0;
            step();
            check("gap_valid", 64'(ov_a), 64'd0);
            check("gap_data", 64'(od_a), (n >= 2) ? 64'(n - 2) : 64'd0);
            check("gap_fill", 64'(of_a), (n >= 1) ? 64'd2 : 64'd1);
        end

        // Flush alone after input 5
        pulse_reset_a();
        for (int n = 0; n < 6; n++)
            beat_a(8'(n), (n >= 2) ? 8'(n - 2) : 8'd0, n >= 2, (n >= 1) ? 2'd2 : 2'd1);
        v_a = 1'b0; f_a = 1'b1;
        step();
        check("flush_fill", 64'(of_a), 64'd0);
        check("flush_valid", 64'(ov_a), 64'd0);
        check("flush_data_hold", 64'(od_a), 64'd3);
        beat_a(8'd20, 8'd0, 1'b0, 2'd1);
        beat_a(8'd21, 8'd0, 1'b0, 2'd2);
        beat_a(8'd22, 8'd20, 1'b1, 2'd2);

        // Flush coincident with a beat keeps the new sample
        v_a = 1'b1; f_a = 1'b1; d_a = 8'h33;
        step();
        check("fb_fill", 64'(of_a), 64'd1);
        check("fb_valid", 64'(ov_a), 64'd0);
        check("fb_data_hold", 64'(od_a), 64'd20);
        beat_a(8'h34, 8'h00, 1'b0, 2'd2);
        beat_a(8'h35, 8'h33, 1'b1, 2'd2);
        v_a = 1'b0;

        // DEPTH=1: valid from beat 1 onward
        rst_1 = 1'b0;
        v_1 = 1'b1;
        for (int n = 0; n < 3; n++) begin
            d_1 = 8'(5 + n);
            step();
            check("d1_fill", 64'(of_1), 64'd1);
            check("d1_valid", 64'(ov_1), (n >= 1) ? 64'd1 : 64'd0);
            check("d1_data", 64'(od_1), (n >= 1) ? 64'(4 + n) : 64'd0);
        end
        v_1 = 1'b0;
        step();
        check("d1_idle_valid", 64'(ov_1), 64'd0);
        check("d1_idle_data", 64'(od_1), 64'd6);

        // Three lanes, DEPTH=4
        rst_m = 1'b0;
        v_m = 1'b1;
        for (int n = 0; n < 8; n++) begin
            d_m = {8'(20 + n), 8'(10 + n), 8'(n)};
            step();
            check("m_fill", 64'(of_m), (n >= 3) ? 64'd4 : 64'(n + 1));
            check("m_valid", 64'(ov_m), (n >= 4) ? 64'd1 : 64'd0);
            for (int c = 0; c < 3; c++) begin
                logic [23:0] od_tmp;
                od_tmp = od_m;
                check($sformatf("m_data_l%0d_n%0d", c, n), 64'(od_tmp[c*8 +: 8]),
                      (n >= 4) ? 64'(10 * c + n - 4) : 64'd0);
`ifdef STREAM_DELAY_SUM_EN
                begin
                    int          exp_sum;
                    logic [32:0] sum_tmp;
                    exp_sum = 0;
                    for (int k = (n >= 3 ? n - 3 : 0); k <= n; k++) exp_sum += 10 * c + k;
                    sum_tmp = sum_m;
                    check($sformatf("m_sum_l%0d_n%0d", c, n), 64'(sum_tmp[c*11 +: 11]),
                          64'(exp_sum));
                end
`endif
            end
        end

        // Mid-stream reset discards everything, asynchronously
        d_m = 24'($urandom);
        rst_m = 1'b1;
        #1;
        check_m_zero("m_rst_async");
        step();
        check_m_zero("m_rst_held");
        rst_m = 1'b0; v_m = 1'b0;
        step();
        check_m_zero("m_rst_after");
        v_m = 1'b1;
        d_m = {8'd20, 8'd10, 8'd0};
        step();
        check("m_b0_fill", 64'(of_m), 64'd1);
        check("m_b0_valid", 64'(ov_m), 64'd0);
        check("m_b0_data", 64'(od_m), 64'd0);
`ifdef STREAM_DELAY_SUM_EN
        check("m_b0_sum", 64'(sum_m), 64'({11'd20, 11'd10, 11'd0}));
`endif
        v_m = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
